// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data load/store. Accesses run through a registered IDLE/D_ACC/I_ACC
// state machine with variable-latency acknowledge and a hung-memory timeout.
// Optional feature macro: ARB_PERF_CNT_EN (adds stall_cycles / fetch_cycles).
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DATA_BASE = 1024,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              freeze,
  output logic              if_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       fetch_cycles,
`endif
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_D_ACC, S_I_ACC} state_t;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(DATA_BASE);
  localparam logic [7:0]        TO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_last_d;   // 1: last grant went to data, 0: to fetch
  logic [7:0]        r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_ready;
  logic              r_d_ready;
  logic              r_err;

  logic              w_dreq;
  logic              w_d_pend;
  logic              w_i_pend;
  logic              w_grant_d;
  logic              w_grant_i;
  logic [ADDR_W-1:0] w_d_off;

  // A requester whose ready pulse is showing this cycle still holds its
  // request; mask it so the completed access is not granted a second time.
  assign w_dreq    = d_rd | d_wr;
  assign w_d_pend  = w_dreq & ~r_d_ready;
  assign w_i_pend  = if_req & ~r_if_ready;
  assign w_grant_d = w_d_pend & (~w_i_pend | ~r_last_d);
  assign w_grant_i = w_i_pend & ~w_grant_d;
  assign w_d_off   = d_addr - BASE;

  assign freeze    = w_dreq & ~r_d_ready;
  assign if_stall  = if_req & ~r_if_ready;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ready  = r_if_ready;
  assign d_ready   = r_d_ready;
  assign err       = r_err;

  // Access sequencer: arbitration, held memory strobes, completion and timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_d    <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_d) begin
            r_state     <= S_D_ACC;
            r_mem_en    <= 1'b1;
            r_mem_we    <= d_wr;
            r_mem_addr  <= w_d_off >> 2;
            r_mem_wdata <= d_wdata;
            r_last_d    <= 1'b1;
          end else if (w_grant_i) begin
            r_state    <= S_I_ACC;
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= if_addr >> 2;
            r_last_d   <= 1'b0;
          end
        end
        S_D_ACC: begin
          if (mem_ack) begin
            r_state   <= S_IDLE;
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_d_ready <= w_dreq;
            if (!r_mem_we) r_d_rdata <= mem_rdata;
          end else if (r_cnt == TO_LAST) begin
            r_state   <= S_IDLE;
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_d_ready <= 1'b1;
            r_d_rdata <= '0;
            r_err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_I_ACC: begin
          if (mem_ack) begin
            r_state    <= S_IDLE;
            r_mem_en   <= 1'b0;
            r_if_ready <= if_req;
            r_if_rdata <= mem_rdata;
          end else if (r_cnt == TO_LAST) begin
            r_state    <= S_IDLE;
            r_mem_en   <= 1'b0;
            r_if_ready <= 1'b1;
            r_if_rdata <= '0;
            r_err      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_fetch_cycles;

  assign stall_cycles = r_stall_cycles;
  assign fetch_cycles = r_fetch_cycles;

  // Performance counters: saturating freeze cycles and granted fetch cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_fetch_cycles <= '0;
    end else begin
      if (freeze && r_stall_cycles != 32'hFFFF_FFFF)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (r_state == S_I_ACC)
        r_fetch_cycles <= r_fetch_cycles + 32'd1;
    end
  end
`endif

endmodule
